// File: rtl/clause_fetch_sequencer_pkg.sv
// Shared constants and FSM encoding for the clause fetch sequencer.
// Optional build macro used by the slice: CLAUSE_SKIP_EN (per-clause enable mask).
package clause_fetch_sequencer_pkg;

  localparam int BIT_WIDTH_OF_INTEGER_VARIABLE = 4;
  localparam int NUMBER_OF_INTEGER_VARIABLES   = 2;
  localparam int NUM_CLAUSES_DEF               = 8;
  localparam int COEFF_W_DEF = BIT_WIDTH_OF_INTEGER_VARIABLE * NUMBER_OF_INTEGER_VARIABLES;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FINISH = 3'd4
  } seq_state_e;

endpackage

// File: rtl/clause_fetch_sequencer_if.sv
// Load / control / issue bundle between the sequencer and its neighbours.
// CLAUSE_SKIP_EN adds in_load_enable to the load group.
interface clause_fetch_sequencer_if #(
  parameter int IDX_W   = 3,
  parameter int COEFF_W = 8
);
  logic               in_load_valid;
  logic [IDX_W-1:0]   in_load_index;
  logic [COEFF_W-1:0] in_load_coefficients;
`ifdef CLAUSE_SKIP_EN
  logic               in_load_enable;
`endif
  logic               in_start;
  logic               in_clause_done;
  logic [COEFF_W-1:0] out_clause_coefficients;
  logic               out_write_enable;
  logic [IDX_W-1:0]   out_clause_index;
  logic               out_busy;
  logic               out_sweep_done;

  modport master (
`ifdef CLAUSE_SKIP_EN
    output in_load_enable,
`endif
    output in_load_valid, in_load_index, in_load_coefficients, in_start, in_clause_done,
    input  out_clause_coefficients, out_write_enable, out_clause_index, out_busy, out_sweep_done
  );

  modport slave (
`ifdef CLAUSE_SKIP_EN
    input  in_load_enable,
`endif
    input  in_load_valid, in_load_index, in_load_coefficients, in_start, in_clause_done,
    output out_clause_coefficients, out_write_enable, out_clause_index, out_busy, out_sweep_done
  );
endinterface

// File: rtl/clause_fetch_sequencer_clause_table_ram.sv
// Clause coefficient table: one write port, one registered read port, no reset.
module clause_table_ram #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic          in_clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge in_clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/clause_fetch_sequencer.sv
// Sweeps the clause table one clause at a time, handshaking each issue with in_clause_done.
// Define CLAUSE_SKIP_EN for a per-clause enable mask that skips disabled clauses.
module clause_fetch_sequencer
  import clause_fetch_sequencer_pkg::*;
#(
  parameter int NUM_CLAUSES = NUM_CLAUSES_DEF,
  parameter int IDX_W       = $clog2(NUM_CLAUSES),
  parameter int COEFF_W     = COEFF_W_DEF
) (
  input logic                     in_clk,
  input logic                     in_reset_n,
  clause_fetch_sequencer_if.slave bus
);
  seq_state_e         state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [COEFF_W-1:0] rd_data;
  logic               last, load_we, clause_en, rd_en, issue_nxt, finish_nxt;
  logic               we_q, done_q;
  logic [COEFF_W-1:0] coeff_q;
  logic [IDX_W-1:0]   cidx_q;

  assign last    = (idx == IDX_W'(NUM_CLAUSES - 1));
  assign load_we = bus.in_load_valid && (state == ST_IDLE) &&
                   (int'(bus.in_load_index) < NUM_CLAUSES);

  clause_table_ram #(.DEPTH(NUM_CLAUSES), .AW(IDX_W), .DW(COEFF_W)) u_table (
    .in_clk (in_clk),
    .we     (load_we),
    .waddr  (bus.in_load_index),
    .wdata  (bus.in_load_coefficients),
    .re     (rd_en),
    .raddr  (idx),
    .rdata  (rd_data)
  );

`ifdef CLAUSE_SKIP_EN
  logic [NUM_CLAUSES-1:0] en_mask;
  always_ff @(posedge in_clk) begin
    if (!in_reset_n)  en_mask <= '1;
    else if (load_we) en_mask[bus.in_load_index] <= bus.in_load_enable;
  end
  assign clause_en = en_mask[idx];
`else
  assign clause_en = 1'b1;
`endif

  // Outputs are registered, so each strobe/pulse appears one cycle after its state.
  always_ff @(posedge in_clk) begin
    if (!in_reset_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      coeff_q <= '0;
      cidx_q  <= '0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      we_q   <= issue_nxt;
      done_q <= finish_nxt;
      if (issue_nxt) begin
        coeff_q <= rd_data;
        cidx_q  <= idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_IDLE:
        if (bus.in_start) begin
          state_nxt = ST_FETCH;
          idx_nxt   = '0;
        end
      ST_FETCH:
        if (clause_en)  state_nxt = ST_ISSUE;
        else if (last)  state_nxt = ST_FINISH;
        else            idx_nxt   = idx + 1'b1;
      ST_ISSUE:
        state_nxt = ST_WAIT;
      ST_WAIT:
        if (bus.in_clause_done) begin
          if (last) state_nxt = ST_FINISH;
          else begin
            state_nxt = ST_FETCH;
            idx_nxt   = idx + 1'b1;
          end
        end
      ST_FINISH: begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    rd_en      = (state == ST_FETCH);
    issue_nxt  = (state == ST_ISSUE);
    finish_nxt = (state == ST_FINISH);
  end

  assign bus.out_clause_coefficients = coeff_q;
  assign bus.out_write_enable        = we_q;
  assign bus.out_clause_index        = cidx_q;
  assign bus.out_busy                = (state != ST_IDLE);
  assign bus.out_sweep_done          = done_q;
endmodule

// File: tb/tb_clause_fetch_sequencer.sv
// Directed + randomized bench for clause_fetch_sequencer against a table/timing reference model.
module tb_clause_fetch_sequencer;
  localparam int N  = 8;
  localparam int IW = 3;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [CW-1:0] tbl [N];
  bit            en_m [N];

  clause_fetch_sequencer_if #(.IDX_W(IW), .COEFF_W(CW)) bus ();

  clause_fetch_sequencer #(.NUM_CLAUSES(N), .IDX_W(IW), .COEFF_W(CW)) dut (
    .in_clk     (clk),
    .in_reset_n (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_we"},    32'(bus.out_write_enable), 0);
    check({tag, "_coeff"}, 32'(bus.out_clause_coefficients), 0);
    check({tag, "_idx"},   32'(bus.out_clause_index), 0);
    check({tag, "_busy"},  32'(bus.out_busy), 0);
    check({tag, "_done"},  32'(bus.out_sweep_done), 0);
  endtask

  task automatic load(input int i, input logic [CW-1:0] v, input bit e);
    bus.in_load_valid        = 1'b1;
    bus.in_load_index        = IW'(i);
    bus.in_load_coefficients = v;
`ifdef CLAUSE_SKIP_EN
    bus.in_load_enable       = e;
`endif
    tick();
    bus.in_load_valid = 1'b0;
    tbl[i]  = v;
    en_m[i] = e;
  endtask

  // Model: enabled clauses issue in order, strobe 3 cycles after start/done is driven.
  task automatic sweep(input int reset_at, input int hold_at, input int poke_at,
                       input bit load0, input logic [CW-1:0] v0);
    bus.in_start = 1'b1;
    if (load0) begin
      bus.in_load_valid        = 1'b1;
      bus.in_load_index        = '0;
      bus.in_load_coefficients = v0;
`ifdef CLAUSE_SKIP_EN
      bus.in_load_enable       = 1'b1;
`endif
      tbl[0]  = v0;
      en_m[0] = 1'b1;
    end
    tick();
    bus.in_start      = 1'b0;
    bus.in_load_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      check("busy_fetch", 32'(bus.out_busy), 1);
      check("we_fetch", 32'(bus.out_write_enable), 0);
      tick();
      if (!en_m[i]) continue;
      check("we_issue", 32'(bus.out_write_enable), 0);
      tick();
      check("we_strobe", 32'(bus.out_write_enable), 1);
      check("coeff", 32'(bus.out_clause_coefficients), 32'(tbl[i]));
      check("index", 32'(bus.out_clause_index), i);
      if (i == reset_at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_quiet("mid_reset");
        repeat (2) begin
          tick();
          check("post_reset_done", 32'(bus.out_sweep_done), 0);
          check("post_reset_busy", 32'(bus.out_busy), 0);
        end
        return;
      end
      if (i == hold_at) begin
        repeat (20) begin
          tick();
          check("hold_we", 32'(bus.out_write_enable), 0);
          check("hold_busy", 32'(bus.out_busy), 1);
          check("hold_coeff", 32'(bus.out_clause_coefficients), 32'(tbl[i]));
          check("hold_idx", 32'(bus.out_clause_index), i);
        end
      end
      if (i == poke_at) begin
        bus.in_start             = 1'b1;
        bus.in_load_valid        = 1'b1;
        bus.in_load_index        = 3'd3;
        bus.in_load_coefficients = 8'hFF;
        tick();
        bus.in_start      = 1'b0;
        bus.in_load_valid = 1'b0;
        check("poke_we", 32'(bus.out_write_enable), 0);
        check("poke_busy", 32'(bus.out_busy), 1);
      end
      repeat ($urandom_range(0, 2)) begin
        tick();
        check("wait_we", 32'(bus.out_write_enable), 0);
      end
      bus.in_clause_done = 1'b1;
      tick();
      bus.in_clause_done = 1'b0;
    end
    check("finish_busy", 32'(bus.out_busy), 1);
    check("finish_done", 32'(bus.out_sweep_done), 0);
    tick();
    check("sweep_done", 32'(bus.out_sweep_done), 1);
    check("idle_busy", 32'(bus.out_busy), 0);
    check("idle_we", 32'(bus.out_write_enable), 0);
    tick();
    check("sweep_done_end", 32'(bus.out_sweep_done), 0);
  endtask

  initial begin
    bus.in_load_valid        = 1'b0;
    bus.in_load_index        = '0;
    bus.in_load_coefficients = '0;
`ifdef CLAUSE_SKIP_EN
    bus.in_load_enable       = 1'b1;
`endif
    bus.in_start       = 1'b0;
    bus.in_clause_done = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    check_quiet("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < N; i++) load(i, CW'(8'hA0 + i), 1'b1);
    sweep(-1, -1, -1, 1'b0, '0);

    for (int i = 0; i < N; i++) load(i, CW'($urandom), 1'b1);
    sweep(-1, 2, 1, 1'b0, '0);

    sweep(4, -1, -1, 1'b0, '0);
    sweep(-1, -1, -1, 1'b0, '0);

    sweep(-1, -1, -1, 1'b1, CW'($urandom));

`ifdef CLAUSE_SKIP_EN
    for (int i = 0; i < N; i++) load(i, CW'($urandom), (i != 1) && (i != 6));
    sweep(-1, -1, -1, 1'b0, '0);
    for (int i = 0; i < N; i++) load(i, CW'($urandom), 1'b0);
    sweep(-1, -1, -1, 1'b0, '0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
